// File: rtl/segment7_scanner.sv
// segment7_scanner
//   Multiplexed driver for a 4-digit, common-anode 7-segment display.
//   A free-running divider produces a one-cycle scan tick. Each tick selects
//   the next digit in the order 3 -> 0 -> 1 -> 2 -> 3. Loads go into a shadow
//   register and reach the display copy only at a frame boundary, which is a
//   tick taken while digit 3 is selected. A frame is therefore never torn.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   value_in   four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3
//   dp_in      per-digit decimal point, 1 = lit
//   blank_in   per-digit blank, 1 = digit dark
//   load       single-cycle strobe that captures value_in/dp_in/blank_in
//   pending    high while a captured load waits for its commit
//   segs       active-low cathodes, bit0=a .. bit6=g, bit7=dp
//   ssd_ctl    active-low anodes, one-hot-low, bit n = digit n
//   frame_done one-cycle pulse when digit 0 of a new frame is shown
module segment7_scanner #(
  parameter int SCAN_DIV_BITS  = 20,
  parameter int SCAN_DIV_COUNT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic        pending,
  output logic [7:0]  segs,
  output logic [3:0]  ssd_ctl,
  output logic        frame_done
);

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } frame_t;

  localparam logic [SCAN_DIV_BITS-1:0] LAST = SCAN_DIV_BITS'(SCAN_DIV_COUNT - 1);

  logic [SCAN_DIV_BITS-1:0] counter;
  logic [1:0]               digit_sel;
  logic [1:0]               digit_sel_next;
  logic                     tick;
  logic                     boundary;
  frame_t                   shadow_q;
  frame_t                   display_q;
  frame_t                   display_next;
  frame_t                   in_frame;
  logic [3:0]               nibble;

  // Active-low segment pattern for one hex digit, segs[6:0].
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign in_frame = '{value: value_in, dp: dp_in, blank: blank_in};
  assign tick     = (counter == LAST);
  assign boundary = tick && (digit_sel == 2'd3);

  // 3 -> 0 wraps naturally in two bits.
  assign digit_sel_next = tick ? digit_sel + 2'd1 : digit_sel;

  // The display copy that the coming slot will show. A load that arrives on
  // the boundary itself bypasses the shadow, so it still makes this frame.
  always_comb begin
    // NOTE: assign a default before any branch so no path holds a stale
    // value, which would otherwise infer a latch.
    display_next = display_q;
    if (boundary) begin
      if (load)         display_next = in_frame;
      else if (pending) display_next = shadow_q;
    end
  end

  assign nibble = display_next.value[{digit_sel_next, 2'b00} +: 4];

  // NOTE: all state uses non-blocking assignments. Every register then
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: display and shadow are reset like all other state. They feed
      // the pins directly, so reset must leave no stale digits on show.
      counter    <= '0;
      digit_sel  <= 2'd3;
      shadow_q   <= '0;
      display_q  <= '0;
      pending    <= 1'b0;
      segs       <= 8'hFF;
      ssd_ctl    <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      counter    <= tick ? '0 : counter + SCAN_DIV_BITS'(1);
      digit_sel  <= digit_sel_next;
      display_q  <= display_next;
      frame_done <= boundary;

      if (load) shadow_q <= in_frame;
      if (boundary)  pending <= 1'b0;
      else if (load) pending <= 1'b1;

      if (tick) begin
        if (display_next.blank[digit_sel_next]) begin
          segs    <= 8'hFF;
          ssd_ctl <= 4'b1111;
        end else begin
          segs    <= {~display_next.dp[digit_sel_next], decode(nibble)};
          ssd_ctl <= ~(4'b0001 << digit_sel_next);
        end
      end
    end
  end

endmodule
